la_trigger_capture: RTL
=======================

Name: la_trigger_capture

Overview:
- Multi-channel logic-analyser front end: samples `din` at a programmable divided rate and holds a configurable pre-trigger history.
- Evaluates edge or pattern trigger conditions and streams pre-trigger plus post-trigger samples over a valid/ready interface.
- Sits between the probe pins and the DDR/AXI write path, replacing the fixed 6-channel, single-channel-trigger capture front end.

Parameters:
- CH_NUM, 8, number of probe channels (1..32).
- PRE_DEPTH, 256, pre-trigger/elastic FIFO depth; power of two.
- CNT_W, 32, width of the post-trigger sample counter.
- DIV_W, 4, width of the sample-rate divider.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  CH_NUM  probe inputs (asynchronous).
- cfg_div  in  DIV_W  sample every cfg_div+1 clocks.
- cfg_trig_mode  in  3  0 immediate, 1 rising, 2 falling, 3 either edge, 4 pattern; 5-7 behave as immediate.
- cfg_trig_ch  in  $clog2(CH_NUM) (min 1)  edge-trigger channel.
- cfg_pat_mask  in  CH_NUM  pattern care bits.
- cfg_pat_val  in  CH_NUM  pattern value.
- cfg_pre_num  in  $clog2(PRE_DEPTH)+1  requested pre-trigger samples.
- cfg_post_num  in  CNT_W  post-trigger samples, including the trigger sample.
- start  in  1  one-cycle arm pulse.
- abort  in  1  one-cycle cancel pulse.
- out_data  out  CH_NUM  sample.
- out_valid  out  1  sample available.
- out_ready  in  1  downstream accept.
- out_last  out  1  final sample of the capture.
- busy  out  1  state is not IDLE.
- triggered  out  1  trigger has been seen this capture.
- overflow  out  1  sticky: a sample was dropped.
- done  out  1  one-cycle pulse when the capture completes.

Behaviour:
- Reset: all outputs 0; state IDLE; FIFO empty; counters 0.
- Input path: `din` passes through a 2-flop synchronizer (2-cycle latency) before sampling.
- Sample tick:
  - Divider counts 0..cfg_div; tick when count == cfg_div.
  - cfg_div = 0 gives a tick every clock.
  - Divider restarts at 0 on start.
- Configuration: all cfg_* values are latched on start; changes while busy are ignored.
- Pre-trigger clamp: cfg_pre_num > PRE_DEPTH-1 is clamped to PRE_DEPTH-1.
- Post-trigger clamp: cfg_post_num = 0 is treated as 1.
- States and transitions:
  - IDLE: on start go to PRETRIG and clear triggered, overflow and counters. start while busy is ignored.
  - PRETRIG: each tick writes the sample to the FIFO.
    - If the FIFO count would exceed the latched pre_num, the oldest entry is popped and discarded in the same cycle.
    - pre_num = 0 means nothing is retained.
    - The trigger is evaluated on every tick, on the current sample versus the previous tick's sample.
    - The first tick after start has no previous sample, so edge modes cannot fire on it. Immediate mode fires on the first tick.
    - Pattern mode fires when ((sample ^ pat_val) & pat_mask) == 0.
    - On fire: the triggering sample is written without any discard, triggered = 1, post_cnt = 1, go to CAPTURE.
    - If post_num == 1, go directly to DRAIN.
    - The trigger does not wait for the pre-buffer to fill; fewer than pre_num pre samples is legal.
  - CAPTURE:
    - Each tick writes a sample and increments post_cnt.
    - If the FIFO is full at a tick, the sample is dropped and overflow is set; post_cnt still increments.
    - When post_cnt reaches post_num, go to DRAIN.
  - DRAIN: no writes. When the FIFO becomes empty after the final pop, pulse done and go to IDLE.
- Output handshake:
  - out_valid = FIFO non-empty and state in {CAPTURE, DRAIN}; it is never asserted in PRETRIG.
  - Transfer happens on out_valid & out_ready.
  - out_data and out_last are held stable while out_valid & !out_ready.
  - A write and a pop in the same cycle are both performed; the count is unchanged.
- out_last: 1 when in DRAIN and FIFO count == 1.
- Sample totals:
  - Total samples out = pre_held + post_num − dropped.
  - Sample order: oldest pre sample first, trigger sample immediately after the pre samples.
- abort: in any state, next cycle is IDLE, FIFO flushed, out_valid = 0, done not pulsed, overflow/triggered retain their values. Abort has priority over start in the same cycle.
- Reset mid-operation returns everything to reset values immediately.

Test Plan:
- Rising-edge capture:
  - Stimulus: CH_NUM=8, div=0, mode=1, ch=2, pre=4, post=8, out_ready=1; din counts 0,1,2,…; bit 2 first rises at value 4.
  - Response: 12 outputs. Outputs 0-3 are the four samples before the trigger (0x00-0x03 for this count stimulus: the bench drives no samples before 0x00, so pre_held = 4). Output 4 is 0x04. out_last is on the 12th output; one done pulse follows.
- Immediate mode:
  - Stimulus: mode=0, pre=16, post=5.
  - Response: exactly 5 outputs (the first 5 post-start samples); out_last on the 5th.
- Pre-buffer wrap:
  - Stimulus: pre=4; pattern trigger (mask=0xFF, val=0xA5) occurs after 100 ticks.
  - Response: only the 4 samples immediately preceding 0xA5 are emitted, then 0xA5.
- Divider:
  - Stimulus: div=3, mode=0, post=4.
  - Response: consecutive written samples are 4 clocks apart; din changing every clock yields every 4th value.
- Backpressure and overflow:
  - Stimulus: PRE_DEPTH=16, pre=0, post=40, out_ready=0 for 30 ticks after the trigger, then 1.
  - Response: overflow=1; 16 outputs; data is held stable while stalled.
- Abort and start-while-busy:
  - Stimulus: abort during CAPTURE with 3 samples queued; separately, start while busy.
  - Response: on abort, out_valid=0 next cycle, busy=0, no done pulse. The start while busy has no effect.

Source files
------------

// File: rtl/la_trigger_capture.sv
// Logic-analyser capture front end: synchronised, rate-divided sampling with an
// edge/pattern trigger and a pre-trigger history FIFO streamed over valid/ready.
module la_trigger_capture #(
  parameter int CH_NUM    = 8,
  parameter int PRE_DEPTH = 256,
  parameter int CNT_W     = 32,
  parameter int DIV_W     = 4,
  localparam int CH_W     = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
  localparam int AW       = (PRE_DEPTH > 1) ? $clog2(PRE_DEPTH) : 1,
  localparam int PW       = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CH_NUM-1:0] din,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [2:0]        cfg_trig_mode,
  input  logic [CH_W-1:0]   cfg_trig_ch,
  input  logic [CH_NUM-1:0] cfg_pat_mask,
  input  logic [CH_NUM-1:0] cfg_pat_val,
  input  logic [PW-1:0]     cfg_pre_num,
  input  logic [CNT_W-1:0]  cfg_post_num,
  input  logic              start,
  input  logic              abort,
  output logic [CH_NUM-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              triggered,
  output logic              overflow,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, PRETRIG, CAPTURE, DRAIN} state_t;

  localparam logic [PW-1:0] PRE_MAX  = PW'(PRE_DEPTH - 1);
  localparam logic [PW-1:0] FULL_CNT = PW'(PRE_DEPTH);

  state_t state_reg, state_next;

  logic [CH_NUM-1:0] din_meta_reg, din_sync_reg;
  logic [DIV_W-1:0]  div_cnt_reg;
  logic [DIV_W-1:0]  div_lat_reg;
  logic [2:0]        mode_lat_reg;
  logic [CH_W-1:0]   ch_lat_reg;
  logic [CH_NUM-1:0] mask_lat_reg, val_lat_reg;
  logic [PW-1:0]     pre_lat_reg;
  logic [CNT_W-1:0]  post_lat_reg;
  logic [CNT_W-1:0]  post_cnt_reg;
  logic [CH_NUM-1:0] prev_reg;
  logic              first_reg;
  logic              triggered_reg, overflow_reg, done_reg;

  logic [CH_NUM-1:0] mem [PRE_DEPTH];
  logic [CH_NUM-1:0] rd_q_reg;
  logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg, wr_ptr_next, rd_ptr_next;
  logic [PW-1:0]     count_reg, count_next;

  logic active, tick, fire, full, pop_out, pop;
  logic wr_en, discard, start_cap, trig_now, post_inc, drop, finish, flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_meta_reg <= '0;
      din_sync_reg <= '0;
    end else begin
      din_meta_reg <= din;
      din_sync_reg <= din_meta_reg;
    end
  end

  assign active    = (state_reg == PRETRIG) || (state_reg == CAPTURE);
  assign tick      = active && (div_cnt_reg == div_lat_reg);
  assign full      = (count_reg == FULL_CNT);
  assign out_valid = (count_reg != '0) && ((state_reg == CAPTURE) || (state_reg == DRAIN));
  assign pop_out   = out_valid && out_ready;
  assign pop       = pop_out || discard;

  // Edge modes compare against the previous tick's sample, so they are masked on the first tick.
  always_comb begin
    fire = 1'b1;
    case (mode_lat_reg)
      3'd1: fire = !first_reg && !prev_reg[ch_lat_reg] && din_sync_reg[ch_lat_reg];
      3'd2: fire = !first_reg && prev_reg[ch_lat_reg] && !din_sync_reg[ch_lat_reg];
      3'd3: fire = !first_reg && (prev_reg[ch_lat_reg] ^ din_sync_reg[ch_lat_reg]);
      3'd4: fire = ((din_sync_reg ^ val_lat_reg) & mask_lat_reg) == '0;
      default: fire = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    wr_en      = 1'b0;
    discard    = 1'b0;
    start_cap  = 1'b0;
    trig_now   = 1'b0;
    post_inc   = 1'b0;
    drop       = 1'b0;
    finish     = 1'b0;
    flush      = 1'b0;
    if (abort) begin
      state_next = IDLE;
      flush      = 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_next = PRETRIG;
            start_cap  = 1'b1;
            flush      = 1'b1;
          end
        end
        PRETRIG: begin
          if (tick) begin
            if (fire) begin
              wr_en      = 1'b1;
              trig_now   = 1'b1;
              state_next = (post_lat_reg == CNT_W'(1)) ? DRAIN : CAPTURE;
            end else if (pre_lat_reg != '0) begin
              wr_en   = 1'b1;
              discard = (count_reg == pre_lat_reg);
            end
          end
        end
        CAPTURE: begin
          if (tick) begin
            post_inc = 1'b1;
            if (full) drop = 1'b1;
            else      wr_en = 1'b1;
            if (post_cnt_reg + CNT_W'(1) == post_lat_reg) state_next = DRAIN;
          end
        end
        DRAIN: begin
          if ((count_reg == '0) || ((count_reg == PW'(1)) && pop_out)) begin
            state_next = IDLE;
            finish     = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_lat_reg  <= '0;
      mode_lat_reg <= '0;
      ch_lat_reg   <= '0;
      mask_lat_reg <= '0;
      val_lat_reg  <= '0;
      pre_lat_reg  <= '0;
      post_lat_reg <= '0;
    end else if (start_cap) begin
      div_lat_reg  <= cfg_div;
      mode_lat_reg <= cfg_trig_mode;
      ch_lat_reg   <= cfg_trig_ch;
      mask_lat_reg <= cfg_pat_mask;
      val_lat_reg  <= cfg_pat_val;
      pre_lat_reg  <= (cfg_pre_num > PRE_MAX) ? PRE_MAX : cfg_pre_num;
      post_lat_reg <= (cfg_post_num == '0) ? CNT_W'(1) : cfg_post_num;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg   <= '0;
      post_cnt_reg  <= '0;
      prev_reg      <= '0;
      first_reg     <= 1'b0;
      triggered_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= finish;
      if (start_cap || tick) div_cnt_reg <= '0;
      else if (active)       div_cnt_reg <= div_cnt_reg + DIV_W'(1);
      if (start_cap) begin
        post_cnt_reg  <= '0;
        first_reg     <= 1'b1;
        triggered_reg <= 1'b0;
        overflow_reg  <= 1'b0;
      end else begin
        if (tick) begin
          prev_reg  <= din_sync_reg;
          first_reg <= 1'b0;
        end
        if (trig_now)      post_cnt_reg <= CNT_W'(1);
        else if (post_inc) post_cnt_reg <= post_cnt_reg + CNT_W'(1);
        if (trig_now) triggered_reg <= 1'b1;
        if (drop)     overflow_reg  <= 1'b1;
      end
    end
  end

  always_comb begin
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      wr_ptr_next = wr_ptr_reg + AW'(wr_en);
      rd_ptr_next = rd_ptr_reg + AW'(pop);
      count_next  = count_reg + PW'(wr_en) - PW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= din_sync_reg;
  end

  // Registered read of the next head; a write landing on that slot is forwarded so an empty FIFO shows it at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 rd_q_reg <= '0;
    else if (wr_en && (wr_ptr_reg == rd_ptr_next)) rd_q_reg <= din_sync_reg;
    else                                        rd_q_reg <= mem[rd_ptr_next];
  end

  assign out_data  = rd_q_reg;
  assign out_last  = (state_reg == DRAIN) && (count_reg == PW'(1));
  assign busy      = (state_reg != IDLE);
  assign triggered = triggered_reg;
  assign overflow  = overflow_reg;
  assign done      = done_reg;

endmodule
